// File: rtl/inst_prefetch_if.sv
// Prefetch bus bundle: instruction-memory request/response plus fetch-stage port.
// Pure wiring, no latency of its own.
// The master side (prefetcher) drives mem_req/mem_addr and the ir_* head outputs.
interface inst_prefetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, ir_valid, ir, ir_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, ir_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, ir_valid, ir, ir_pc,
        output mem_gnt, mem_rvalid, mem_rdata, ir_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: sequential word reads ahead of fetch, in-order delivery, flush on redirect.
// Latency: response written in cycle N is visible on ir_valid in N+1; redirect in N gives new mem_req in N+1.
// Backpressure: ir_ready low holds the head; requests stop once queued + in-flight words reach DEPTH.
module inst_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    inst_prefetch_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   push_pc;
    logic [31:0]   q_ir [DEPTH];
    logic [31:0]   q_pc [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic          running;

    logic          grant;
    logic          rsp_ok;
    logic          rsp_push;
    logic          rsp_drop;
    logic          pop;
    logic [CW-1:0] grant_w;
    logic [CW-1:0] rsp_ok_w;
    logic [CW-1:0] rsp_push_w;
    logic [CW-1:0] rsp_drop_w;
    logic [CW-1:0] pop_w;

    // Sequential word increment; bit 31 (supervisor space) is never carried into.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return {pc[31], pc[30:2] + 29'd1, 2'b00};
    endfunction

    // All outputs come from registered state only; running keeps mem_req low for the first cycle out of reset.
    assign bus.mem_req  = running && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign bus.mem_addr = fetch_pc;
    assign bus.ir_valid = (count != '0);
    assign bus.ir       = bus.ir_valid ? q_ir[rd_ptr] : '0;
    assign bus.ir_pc    = bus.ir_valid ? q_pc[rd_ptr] : '0;

    // A response with nothing pending is a protocol error and is ignored outright.
    assign grant    = bus.mem_req & bus.mem_gnt;
    assign rsp_ok   = bus.mem_rvalid && ((outstanding != '0) || (discard != '0));
    assign rsp_drop = rsp_ok && (discard != '0);
    assign rsp_push = rsp_ok && (discard == '0);
    assign pop      = bus.ir_valid & bus.ir_ready;

    assign grant_w    = CW'(grant);
    assign rsp_ok_w   = CW'(rsp_ok);
    assign rsp_push_w = CW'(rsp_push);
    assign rsp_drop_w = CW'(rsp_drop);
    assign pop_w      = CW'(pop);

    // Control state: PCs, pointers and the three occupancy counters; redirect overrides push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            running     <= 1'b0;
            fetch_pc    <= RESET_PC;
            push_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            running <= 1'b1;
            if (bus.redirect) begin
                // Everything still owed by memory, including a grant happening now, becomes discard.
                fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
                push_pc     <= {bus.redirect_pc[31:2], 2'b00};
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                outstanding <= '0;
                discard     <= discard + outstanding + grant_w - rsp_ok_w;
            end else begin
                if (grant) begin
                    fetch_pc <= next_pc(fetch_pc);
                end
                if (rsp_push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    push_pc <= next_pc(push_pc);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count       <= count + rsp_push_w - pop_w;
                outstanding <= outstanding + grant_w - rsp_push_w;
                discard     <= discard - rsp_drop_w;
            end
        end
    end

    // Queue storage: write the returned word with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (!rst && !bus.redirect && rsp_push) begin
            q_ir[wr_ptr] <= bus.mem_rdata;
            q_pc[wr_ptr] <= push_pc;
        end
    end
endmodule
